hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the pipelined MIPS core; sits beside the D stage.
- Replaces per-stage opcode-class forwarding enables with a scoreboard of in-flight destination registers. Each entry carries a Tnew countdown, checked against each D-stage read port's Tuse to give a per-port forward source and a global stall.
- Also tracks the multi-cycle multiply/divide unit, so HI/LO users stall while it is busy.

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : D-stage scoreboard of in-flight destinations with Tnew/Tuse
//            forwarding select, global stall and MDU busy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SW       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [NUM_RD*5-1:0]  d_rs,
    input  logic [NUM_RD*TW-1:0] d_tuse,
    input  logic [4:0]           d_wdst,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_md_start,
    input  logic                 d_md_div,
    input  logic                 d_md_use,
    output logic                 stall,
    output logic [NUM_RD*SW-1:0] fwd_sel,
    output logic [NUM_RD-1:0]    fwd_rdy,
    output logic                 md_busy
);

    localparam int c_md_max = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_md_w   = $clog2(c_md_max + 1);
    localparam logic [c_md_w-1:0] c_mult_lat = c_md_w'(MULT_LAT);
    localparam logic [c_md_w-1:0] c_div_lat  = c_md_w'(DIV_LAT);

    // Index 0 holds stage 1 (E); index DEPTH-1 holds the oldest tracked stage.
    logic [DEPTH-1:0]  v_q, v_d;
    logic [4:0]        dst_q  [DEPTH];
    logic [4:0]        dst_d  [DEPTH];
    logic [TW-1:0]     tnew_q [DEPTH];
    logic [TW-1:0]     tnew_d [DEPTH];
    logic [c_md_w-1:0] md_cnt_q, md_cnt_d;

    logic [NUM_RD-1:0] w_port_haz;
    logic              w_md_haz;

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        fwd_sel    = '0;
        fwd_rdy    = '0;
        w_port_haz = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (v_q[k] && (d_rs[5*p +: 5] != 5'd0) && (d_rs[5*p +: 5] == dst_q[k])) begin
                    fwd_sel[SW*p +: SW] = SW'(k + 1);
                    fwd_rdy[p]          = (tnew_q[k] == '0);
                    w_port_haz[p]       = (tnew_q[k] > d_tuse[TW*p +: TW]);
                end
            end
        end
    end

    assign md_busy  = (md_cnt_q != '0);
    assign w_md_haz = d_valid && d_md_use && md_busy;
    assign stall    = (|w_port_haz) || w_md_haz;

    always_comb begin
        v_d       = '0;
        dst_d[0]  = '0;
        tnew_d[0] = '0;
        md_cnt_d  = md_cnt_q;
        for (int k = 1; k < DEPTH; k++) begin
            dst_d[k]  = '0;
            tnew_d[k] = '0;
        end

        // A stalled D instruction is replaced by a bubble entering E.
        if (!stall) begin
            v_d[0]    = d_valid && (d_wdst != 5'd0);
            dst_d[0]  = d_wdst;
            tnew_d[0] = d_tnew;
        end

        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]    = v_q[k-1];
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end

        if (d_valid && d_md_start && !stall) begin
            md_cnt_d = d_md_div ? c_div_lat : c_mult_lat;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - c_md_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q      <= '0;
            md_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k]  <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            v_q      <= v_d;
            md_cnt_q <= md_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k]  <= dst_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

endmodule
`default_nettype wire
